// File: rtl/uart_cmd_engine_pkg.sv
// Shared types, ASCII constants and nibble/ASCII helpers for the UART command engine.
package uart_cmd_pkg;

    typedef enum logic [1:0] {S_RECV, S_EXEC, S_CLOCK, S_REPLY} state_t;
    typedef enum logic [1:0] {RPL_OK, RPL_ERR, RPL_HEX} reply_t;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_O  = 8'h4F;
    localparam logic [7:0] ASC_K  = 8'h4B;
    localparam logic [7:0] ASC_E  = 8'h45;
    localparam logic [7:0] ASC_R  = 8'h52;

    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_M = 8'h4D;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_G = 8'h47;

    // Returns {valid, nibble}; letters A-F/a-f share low nibble 1..6, hence the +9.
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

    function automatic logic [7:0] nib2asc(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : {4'h4, n - 4'd9};
    endfunction

endpackage

// File: rtl/cmd_reply_tx.sv
// Streams one reply (OK / ERR / hex value) to the UART transmitter, one byte per
// tx_ready handshake, inserting a line feed whenever the column reaches WRAP_COL.
module cmd_reply_tx
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WRAP_COL = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [1:0]        i_kind,
    input  logic [DATA_W-1:0] i_val,
    input  logic              i_tx_ready,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    output logic              o_done
);

    localparam int NDIG  = DATA_W / 4;
    localparam int COL_W = $clog2(WRAP_COL + 1);

    logic              r_active, r_wait, r_ins, r_start;
    logic [7:0]        r_data;
    logic [3:0]        r_idx;
    logic [1:0]        r_kind;
    logic [DATA_W-1:0] r_val;
    logic [COL_W-1:0]  r_col;

    logic [7:0] w_char;
    logic       w_last;
    logic [3:0] w_nib;
    int         w_sh;

    always_comb begin
        w_char = ASC_LF;
        w_last = 1'b0;
        w_nib  = 4'h0;
        w_sh   = 0;
        case (r_kind)
            RPL_OK: begin
                case (r_idx)
                    4'd0:    w_char = ASC_O;
                    4'd1:    w_char = ASC_K;
                    default: w_char = ASC_LF;
                endcase
                w_last = (r_idx == 4'd2);
            end
            RPL_ERR: begin
                case (r_idx)
                    4'd0:       w_char = ASC_E;
                    4'd1, 4'd2: w_char = ASC_R;
                    default:    w_char = ASC_LF;
                endcase
                w_last = (r_idx == 4'd3);
            end
            default: begin
                if (int'(r_idx) < NDIG) begin
                    w_sh   = (NDIG - 1 - int'(r_idx)) * 4;
                    w_nib  = 4'(r_val >> w_sh);
                    w_char = nib2asc(w_nib);
                end
                w_last = (int'(r_idx) == NDIG);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_wait   <= 1'b0;
            r_ins    <= 1'b0;
            r_start  <= 1'b0;
            r_data   <= 8'h00;
            r_idx    <= 4'd0;
            r_kind   <= 2'd0;
            r_val    <= '0;
            r_col    <= '0;
        end else begin
            r_start <= 1'b0;
            if (!r_active) begin
                if (i_req) begin
                    r_active <= 1'b1;
                    r_kind   <= i_kind;
                    r_val    <= i_val;
                    r_idx    <= 4'd0;
                end
            end else if (!r_wait) begin
                r_start <= 1'b1;
                r_wait  <= 1'b1;
                // A wrap line feed is sent in place of the pending byte, which is retried after it.
                if (r_col == COL_W'(WRAP_COL)) begin
                    r_data <= ASC_LF;
                    r_ins  <= 1'b1;
                    r_col  <= '0;
                end else begin
                    r_data <= w_char;
                    r_ins  <= 1'b0;
                    r_col  <= (w_char == ASC_LF) ? '0 : r_col + COL_W'(1);
                end
            end else if (i_tx_ready) begin
                r_wait <= 1'b0;
                if (!r_ins) begin
                    if (w_last) r_active <= 1'b0;
                    else        r_idx    <= r_idx + 4'd1;
                end
            end
        end
    end

    assign o_tx_start = r_start;
    assign o_tx_data  = r_data;
    assign o_done     = r_active && r_wait && i_tx_ready && !r_ins && w_last;

endmodule

// File: rtl/uart_cmd_engine.sv
// Buffers ASCII command lines from the UART, executes them against the CSoC test
// pins (LEDs, data, reset, test mode, clock bursts) and returns an ASCII reply.
module uart_cmd_engine
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LINE_MAX = 16,
    parameter int CNT_W    = 16,
    parameter int CLK_DIV  = 2,
    parameter int WRAP_COL = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              new_rx_data,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_ready_i,
    output logic [DATA_W-1:0] leds,
    output logic              csoc_clk,
    output logic              csoc_rstn,
    output logic              csoc_test_se,
    output logic              csoc_test_tm,
    output logic [DATA_W-1:0] csoc_data_o,
    input  logic [DATA_W-1:0] csoc_data_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int LEN_W = $clog2(LINE_MAX + 1);
    localparam int ARG_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t            r_state;
    logic [7:0]        r_line [LINE_MAX];
    logic [LEN_W-1:0]  r_len;
    logic              r_ovf, r_err, r_req;
    logic [DATA_W-1:0] r_leds, r_data, r_hex;
    logic              r_rstn, r_se, r_tm, r_cclk;
    logic [CNT_W-1:0]  r_burst;
    logic [DIV_W-1:0]  r_div;
    reply_t            r_kind;

    logic             w_valid, w_digits_ok, w_to_clock, w_done;
    logic [ARG_W-1:0] w_arg;
    logic [4:0]       w_nib;
    int               w_ndig, w_max;

    always_comb begin
        w_digits_ok = 1'b1;
        w_arg       = '0;
        w_nib       = 5'b0;
        w_valid     = 1'b0;
        w_ndig      = int'(r_len) - 2;
        w_max       = (r_line[0] == CMD_C) ? CNT_W / 4 : DATA_W / 4;
        for (int i = 2; i < LINE_MAX; i++) begin
            if (i < int'(r_len)) begin
                w_nib       = hex2nib(r_line[i]);
                w_digits_ok = w_digits_ok & w_nib[4];
                w_arg       = (w_arg << 4) | ARG_W'(w_nib[3:0]);
            end
        end
        case (r_line[0])
            CMD_G:                             w_valid = (r_len == LEN_W'(1));
            CMD_L, CMD_D, CMD_R, CMD_M, CMD_C: w_valid = (w_ndig >= 1) && (w_ndig <= w_max) &&
                                                         (r_line[1] == ASC_SP) && w_digits_ok;
            default:                           w_valid = 1'b0;
        endcase
        if (r_ovf) w_valid = 1'b0;
        w_to_clock = w_valid && (r_line[0] == CMD_C) && (w_arg != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RECV;
            for (int i = 0; i < LINE_MAX; i++) r_line[i] <= 8'h00;
            r_len   <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_leds  <= '0;
            r_data  <= '0;
            r_hex   <= '0;
            r_rstn  <= 1'b0;
            r_se    <= 1'b0;
            r_tm    <= 1'b0;
            r_cclk  <= 1'b0;
            r_burst <= '0;
            r_div   <= '0;
            r_kind  <= RPL_OK;
        end else begin
            r_req <= 1'b0;
            if (new_rx_data && r_state != S_RECV) r_err <= 1'b1;
            case (r_state)
                S_RECV: begin
                    if (new_rx_data) begin
                        if (rx_data == ASC_CR || rx_data == ASC_LF) begin
                            if (r_len != '0) r_state <= S_EXEC;
                        end else if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                            if (int'(r_len) < LINE_MAX) begin
                                for (int i = 0; i < LINE_MAX; i++)
                                    if (i == int'(r_len)) r_line[i] <= rx_data;
                                r_len <= r_len + LEN_W'(1);
                            end else begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    r_len  <= '0;
                    r_ovf  <= 1'b0;
                    r_div  <= '0;
                    r_kind <= !w_valid ? RPL_ERR : ((r_line[0] == CMD_G) ? RPL_HEX : RPL_OK);
                    if (w_valid) begin
                        case (r_line[0])
                            CMD_L:   r_leds  <= w_arg[DATA_W-1:0];
                            CMD_D:   r_data  <= w_arg[DATA_W-1:0];
                            CMD_R:   r_rstn  <= w_arg[0];
                            CMD_M:   begin r_tm <= w_arg[0]; r_se <= w_arg[1]; end
                            CMD_C:   r_burst <= w_arg[CNT_W-1:0];
                            CMD_G:   r_hex   <= csoc_data_i;
                            default: ;
                        endcase
                    end
                    r_state <= w_to_clock ? S_CLOCK : S_REPLY;
                    r_req   <= !w_to_clock;
                end
                S_CLOCK: begin
                    // A pulse is counted on its falling edge, so the burst always ends low.
                    if (r_div == DIV_W'(CLK_DIV - 1)) begin
                        r_div  <= '0;
                        r_cclk <= ~r_cclk;
                        if (r_cclk) begin
                            r_burst <= r_burst - CNT_W'(1);
                            if (r_burst == CNT_W'(1)) begin
                                r_state <= S_REPLY;
                                r_req   <= 1'b1;
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_REPLY: if (w_done) r_state <= S_RECV;
                default: r_state <= S_RECV;
            endcase
        end
    end

    cmd_reply_tx #(
        .DATA_W  (DATA_W),
        .WRAP_COL(WRAP_COL)
    ) u_reply (
        .clk       (clk),
        .rst       (rst),
        .i_req     (r_req),
        .i_kind    (r_kind),
        .i_val     (r_hex),
        .i_tx_ready(tx_ready_i),
        .o_tx_start(tx_start_o),
        .o_tx_data (tx_data_o),
        .o_done    (w_done)
    );

    assign leds         = r_leds;
    assign csoc_data_o  = r_data;
    assign csoc_rstn    = r_rstn;
    assign csoc_test_se = r_se;
    assign csoc_test_tm = r_tm;
    assign csoc_clk     = r_cclk;
    assign busy_o       = (r_state != S_RECV);
    assign err_o        = r_err;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed bench: a default-size engine for the command set, plus a 20-bit engine
// with a 4-column wrap to exercise line-feed insertion.
module tb_uart_cmd_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0]  rx0, txd0, leds0, cdo0, cdi0;
    logic        nrx0, txs0, txr0, cclk0, crstn0, cse0, ctm0, busy0, err0;
    logic [7:0]  rx1, txd1;
    logic [19:0] leds1, cdo1, cdi1;
    logic        nrx1, txs1, txr1, cclk1, crstn1, cse1, ctm1, busy1, err1;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       pend0, pend1;
    logic [7:0] hold0, hold1;
    int         dly0, dly1;
    int         last_rises, last_first, last_gapbad;

    always #5 clk = ~clk;

    uart_cmd_engine u_dut (
        .clk(clk), .rst(rst), .rx_data(rx0), .new_rx_data(nrx0),
        .tx_data_o(txd0), .tx_start_o(txs0), .tx_ready_i(txr0), .leds(leds0),
        .csoc_clk(cclk0), .csoc_rstn(crstn0), .csoc_test_se(cse0), .csoc_test_tm(ctm0),
        .csoc_data_o(cdo0), .csoc_data_i(cdi0), .busy_o(busy0), .err_o(err0)
    );

    uart_cmd_engine #(.DATA_W(20), .WRAP_COL(4)) u_wrap (
        .clk(clk), .rst(rst), .rx_data(rx1), .new_rx_data(nrx1),
        .tx_data_o(txd1), .tx_start_o(txs1), .tx_ready_i(txr1), .leds(leds1),
        .csoc_clk(cclk1), .csoc_rstn(crstn1), .csoc_test_se(cse1), .csoc_test_tm(ctm1),
        .csoc_data_o(cdo1), .csoc_data_i(cdi1), .busy_o(busy1), .err_o(err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter models: capture each started byte, answer with tx_ready three cycles later.
    initial begin : resp0
        pend0 = 1'b0; txr0 = 1'b0; hold0 = 8'h00; dly0 = 0;
        forever begin
            @(negedge clk);
            txr0 = 1'b0;
            if (rst) pend0 = 1'b0;
            else if (pend0) begin
                chk("tx_overlap0", {31'b0, txs0}, 32'd0);
                dly0--;
                if (dly0 == 0) begin
                    chk("tx_hold0", {24'b0, txd0}, {24'b0, hold0});
                    txr0 = 1'b1; pend0 = 1'b0;
                end
            end else if (txs0) begin
                q0.push_back(txd0); hold0 = txd0; pend0 = 1'b1; dly0 = 3;
            end
        end
    end

    initial begin : resp1
        pend1 = 1'b0; txr1 = 1'b0; hold1 = 8'h00; dly1 = 0;
        forever begin
            @(negedge clk);
            txr1 = 1'b0;
            if (rst) pend1 = 1'b0;
            else if (pend1) begin
                dly1--;
                if (dly1 == 0) begin
                    chk("tx_hold1", {24'b0, txd1}, {24'b0, hold1});
                    txr1 = 1'b1; pend1 = 1'b0;
                end
            end else if (txs1) begin
                q1.push_back(txd1); hold1 = txd1; pend1 = 1'b1; dly1 = 3;
            end
        end
    end

    task automatic send0(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx0 = s[i]; nrx0 = 1'b1;
            @(negedge clk);
            nrx0 = 1'b0;
        end
    endtask

    task automatic send1(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx1 = s[i]; nrx1 = 1'b1;
            @(negedge clk);
            nrx1 = 1'b0;
        end
    endtask

    // Waits for the engine to return to RECV, logging csoc_clk rising edges on the way.
    task automatic wait_done0();
        logic prev;
        int   last;
        prev = cclk0; last = -1;
        last_rises = 0; last_first = -1; last_gapbad = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cclk0 && !prev) begin
                if (last_rises == 0) last_first = cyc;
                else if (cyc - last != 4) last_gapbad++;
                last = cyc;
                last_rises++;
            end
            prev = cclk0;
            if (!busy0 && !pend0) break;
            @(negedge clk);
        end
        chk("busy_end0", {31'b0, busy0}, 32'd0);
    endtask

    task automatic expect0(input string tag, input string exp);
        chk({tag, "_len"}, q0.size(), exp.len());
        for (int i = 0; i < exp.len() && i < q0.size(); i++)
            chk(tag, {24'b0, q0[i]}, {24'b0, exp[i]});
        q0.delete();
    endtask

    task automatic run0(input string tag, input string cmd, input string reply);
        send0(cmd);
        wait_done0();
        expect0(tag, reply);
    endtask

    task automatic run1(input string tag, input string cmd, input string reply);
        send1(cmd);
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!busy1 && !pend1) break;
            @(negedge clk);
        end
        chk("busy_end1", {31'b0, busy1}, 32'd0);
        chk({tag, "_len"}, q1.size(), reply.len());
        for (int i = 0; i < reply.len() && i < q1.size(); i++)
            chk(tag, {24'b0, q1[i]}, {24'b0, reply[i]});
        q1.delete();
    endtask

    initial begin : main
        rx0 = 8'h00; nrx0 = 1'b0; cdi0 = 8'h00;
        rx1 = 8'h00; nrx1 = 1'b0; cdi1 = 20'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_leds", leds0, 0);
        chk("rst_data", cdo0, 0);
        chk("rst_rstn", crstn0, 0);
        chk("rst_cclk", cclk0, 0);
        chk("rst_se", cse0, 0);
        chk("rst_tm", ctm0, 0);
        chk("rst_txs", txs0, 0);
        chk("rst_txd", txd0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_err", err0, 0);
        rst = 1'b0;
        @(negedge clk);

        run0("L5A", "L 5A\n", "OK\n");
        chk("leds_5A", leds0, 8'h5A);

        run0("C3", "C 3\n", "OK\n");
        chk("c3_rises", last_rises, 3);
        chk("c3_first", last_first, 3);
        chk("c3_gap", last_gapbad, 0);
        chk("c3_end", cclk0, 0);

        run0("D3C", "D 3C\n", "OK\n");
        chk("data_3C", cdo0, 8'h3C);
        run0("R1", "R 1\n", "OK\n");
        chk("rstn_1", crstn0, 1);
        run0("M2", "M 2\n", "OK\n");
        chk("m2_se", cse0, 1);
        chk("m2_tm", ctm0, 0);

        cdi0 = 8'hC3;
        run0("G", "G\n", "C3\n");
        run0("g_lower", "g\n", "ERR\n");
        chk("leds_after_g", leds0, 8'h5A);
        run0("L_long", "L 1F3\n", "ERR\n");
        run0("L_nosp", "L5A\n", "ERR\n");
        run0("G_arg", "G 1\n", "ERR\n");
        run0("L_badhex", "L 5Z\n", "ERR\n");
        chk("leds_kept", leds0, 8'h5A);
        chk("data_kept", cdo0, 8'h3C);
        run0("L_a7", "L a7\n", "OK\n");
        chk("leds_A7", leds0, 8'hA7);
        run0("L_short", "L 2\n", "OK\n");
        chk("leds_02", leds0, 8'h02);
        run0("C0", "C 0\n", "OK\n");
        chk("c0_rises", last_rises, 0);

        run0("ovf", "ABCDEFGHIJKLMNOPQRST\n", "ERR\n");
        send0("\r");
        repeat (20) @(negedge clk);
        chk("empty_busy", busy0, 0);
        chk("empty_tx", q0.size(), 0);
        run0("after_ovf", "L 66\n", "OK\n");
        chk("leds_66", leds0, 8'h66);

        chk("err_before", err0, 0);
        send0("G\n");
        repeat (2) @(negedge clk);
        send0("X");
        chk("err_set", err0, 1);
        wait_done0();
        expect0("G_drop", "C3\n");
        run0("after_drop", "L 11\n", "OK\n");
        chk("leds_11", leds0, 8'h11);
        chk("err_sticky", err0, 1);

        cdi1 = 20'hABCDE;
        run1("wrap1", "G\n", "ABCD\nE\n");
        run1("wrap2", "G\n", "ABCD\nE\n");
        chk("wrap_leds", leds1, 0);
        chk("wrap_data", cdo1, 0);
        chk("wrap_pins", {28'b0, cclk1, crstn1, cse1, ctm1}, 0);
        chk("wrap_err", err1, 0);

        send0("C 8\n");
        for (int i = 0; i < 100 && !cclk0; i++) @(negedge clk);
        chk("burst_high", cclk0, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cclk", cclk0, 0);
        chk("arst_rstn", crstn0, 0);
        chk("arst_txs", txs0, 0);
        chk("arst_leds", leds0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_err", err0, 0);
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        @(negedge clk);
        run0("post_rst", "L 5A\n", "OK\n");
        chk("post_leds", leds0, 8'h5A);
        chk("post_rstn", crstn0, 0);
        chk("post_err", err0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
